// File: rtl/multi_digit_bcd_counter.sv
// multi_digit_bcd_counter
// N-digit packed-BCD up/down counter with a runtime wrap limit, synchronous
// clear, validated parallel load and registered wrap / load-error pulses.
// Cascade stages by wiring one stage's o_carry (or o_borrow) to the next
// stage's i_en.
module multi_digit_bcd_counter #(
    parameter int DIGITS = 2,
    localparam int W = 4 * DIGITS
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_value,
    input  logic         i_en,
    input  logic         i_dir,
    input  logic [W-1:0] i_limit,
    output logic [W-1:0] o_count_out,
    output logic         o_carry,
    output logic         o_borrow,
    output logic         o_load_err
);

    logic [W-1:0]      r_count;
    logic              r_carry;
    logic              r_borrow;
    logic              r_load_err;

    logic [DIGITS-1:0] w_lim_dig_ok;
    logic [DIGITS-1:0] w_lv_dig_ok;
    logic [DIGITS-1:0] w_inc_c;      // carry into digit k during increment
    logic [DIGITS-1:0] w_dec_b;      // borrow into digit k during decrement
    logic [W-1:0]      w_inc;
    logic [W-1:0]      w_dec;
    logic [W-1:0]      w_nines;
    logic [W-1:0]      w_lim_eff;
    logic              w_load_ok;

    // The lowest digit always receives the +1 / -1.
    assign w_inc_c[0] = 1'b1;
    assign w_dec_b[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] w_d;
            assign w_d = r_count[4*gi +: 4];

            assign w_lim_dig_ok[gi]    = (i_limit[4*gi +: 4] <= 4'd9);
            assign w_lv_dig_ok[gi]     = (i_load_value[4*gi +: 4] <= 4'd9);
            assign w_nines[4*gi +: 4]  = 4'd9;

            assign w_inc[4*gi +: 4] = w_inc_c[gi] ? ((w_d == 4'd9) ? 4'd0 : w_d + 4'd1) : w_d;
            assign w_dec[4*gi +: 4] = w_dec_b[gi] ? ((w_d == 4'd0) ? 4'd9 : w_d - 4'd1) : w_d;

            if (gi < DIGITS - 1) begin : g_chain
                assign w_inc_c[gi+1] = w_inc_c[gi] & (w_d == 4'd9);
                assign w_dec_b[gi+1] = w_dec_b[gi] & (w_d == 4'd0);
            end
        end
    endgenerate

    // A limit containing any non-BCD digit falls back to all nines.
    assign w_lim_eff = (&w_lim_dig_ok) ? i_limit : w_nines;
    assign w_load_ok = (&w_lv_dig_ok) && (i_load_value <= w_lim_eff);

    // Count register and one-cycle pulses; priority Rst > Clr > Load > En.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count    <= '0;
            r_carry    <= 1'b0;
            r_borrow   <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_carry    <= 1'b0;
            r_borrow   <= 1'b0;
            r_load_err <= 1'b0;
            if (i_clr) begin
                r_count <= '0;
            end else if (i_load) begin
                if (w_load_ok) begin
                    r_count <= i_load_value;
                end else begin
                    r_count    <= '0;
                    r_load_err <= 1'b1;
                end
            end else if (i_en) begin
                if (i_dir) begin
                    // >= also catches a count stranded above a lowered limit.
                    if (r_count >= w_lim_eff) begin
                        r_count <= '0;
                        r_carry <= 1'b1;
                    end else begin
                        r_count <= w_inc;
                    end
                end else begin
                    if (r_count == '0) begin
                        r_count  <= w_lim_eff;
                        r_borrow <= 1'b1;
                    end else if (r_count > w_lim_eff) begin
                        // Clamp down to the limit without signalling a wrap.
                        r_count <= w_lim_eff;
                    end else begin
                        r_count <= w_dec;
                    end
                end
            end
        end
    end

    assign o_count_out = r_count;
    assign o_carry     = r_carry;
    assign o_borrow    = r_borrow;
    assign o_load_err  = r_load_err;

endmodule

// File: tb/tb_multi_digit_bcd_counter.sv
// Scoreboard bench for multi_digit_bcd_counter: a 2-digit and a 4-digit
// instance. The driver pushes the expected post-edge state per cycle; the
// monitor pops and compares one entry per cycle, 1 ns after the edge.
module tb_multi_digit_bcd_counter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 2-digit instance
    logic        a_rst = 1'b1, a_clr = 1'b0, a_load = 1'b0, a_en = 1'b0, a_dir = 1'b1;
    logic [7:0]  a_lv = 8'h00, a_lim = 8'h59, a_cnt;
    logic        a_c, a_b, a_e;

    // 4-digit instance
    logic        b_rst = 1'b1, b_clr = 1'b0, b_load = 1'b0, b_en = 1'b0, b_dir = 1'b1;
    logic [15:0] b_lv = 16'h0000, b_lim = 16'h9999, b_cnt;
    logic        b_c, b_b, b_e;

    multi_digit_bcd_counter #(.DIGITS(2)) dut2 (
        .i_clk(clk), .i_rst(a_rst), .i_clr(a_clr), .i_load(a_load),
        .i_load_value(a_lv), .i_en(a_en), .i_dir(a_dir), .i_limit(a_lim),
        .o_count_out(a_cnt), .o_carry(a_c), .o_borrow(a_b), .o_load_err(a_e)
    );

    multi_digit_bcd_counter #(.DIGITS(4)) dut4 (
        .i_clk(clk), .i_rst(b_rst), .i_clr(b_clr), .i_load(b_load),
        .i_load_value(b_lv), .i_en(b_en), .i_dir(b_dir), .i_limit(b_lim),
        .o_count_out(b_cnt), .o_carry(b_c), .o_borrow(b_b), .o_load_err(b_e)
    );

    typedef struct {
        bit          sel;   // 0 = dut2, 1 = dut4
        logic [15:0] cnt;
        logic        c, b, e;
        string       name;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Two-digit BCD encoding of 0..99.
    function automatic logic [7:0] bcd2(input int v);
        logic [3:0] t, o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    // Drive one cycle on the selected instance and push its expected result.
    task automatic step(input bit sel, input logic rst, input logic clr, input logic load,
                        input logic [15:0] lv, input logic en, input logic dir,
                        input logic [15:0] lim, input logic [15:0] ec,
                        input logic ecr, input logic ebr, input logic eer, input string nm);
        exp_t x;
        a_rst = 1'b0; a_clr = 1'b0; a_load = 1'b0; a_en = 1'b0;
        b_rst = 1'b0; b_clr = 1'b0; b_load = 1'b0; b_en = 1'b0;
        if (!sel) begin
            a_rst = rst; a_clr = clr; a_load = load; a_lv = lv[7:0];
            a_en = en; a_dir = dir; a_lim = lim[7:0];
        end else begin
            b_rst = rst; b_clr = clr; b_load = load; b_lv = lv;
            b_en = en; b_dir = dir; b_lim = lim;
        end
        @(posedge clk);
        x.sel = sel; x.cnt = ec; x.c = ecr; x.b = ebr; x.e = eer; x.name = nm;
        q.push_back(x);
        #2;
    endtask

    // Monitor: compare one expectation per cycle against the presented outputs.
    initial begin
        exp_t x;
        logic [15:0] act;
        logic ac, ab, ae;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                if (!x.sel) begin
                    act = {8'h00, a_cnt}; ac = a_c; ab = a_b; ae = a_e;
                end else begin
                    act = b_cnt; ac = b_c; ab = b_b; ae = b_e;
                end
                tests++;
                if (act !== x.cnt || ac !== x.c || ab !== x.b || ae !== x.e) begin
                    fails++;
                    $display("FAIL %s: got cnt=%h c=%b b=%b e=%b, expected cnt=%h c=%b b=%b e=%b",
                             x.name, act, ac, ab, ae, x.cnt, x.c, x.b, x.e);
                end else begin
                    $display("[TB] ok %s cnt=%h c=%b b=%b e=%b", x.name, act, ac, ab, ae);
                end
            end
        end
    end

    initial begin
        int guard;
        // Reset both instances
        a_rst = 1'b1; b_rst = 1'b1;
        step(0, 1, 0, 0, 16'h0, 0, 1, 16'h59, 16'h00, 0, 0, 0, "rst2");
        step(1, 1, 0, 0, 16'h0, 0, 1, 16'h9999, 16'h0000, 0, 0, 0, "rst4");

        // Up count 00..59 wrap 00 (Carry) then 01
        for (int i = 1; i <= 61; i++)
            step(0, 0, 0, 0, 16'h0, 1, 1, 16'h59, {8'h00, bcd2(i % 60)},
                 (i == 60), 0, 0, $sformatf("up59_%0d", i));

        // Down count with limit 23 from 00
        step(0, 0, 1, 0, 16'h0, 0, 0, 16'h23, 16'h00, 0, 0, 0, "clr");
        step(0, 0, 0, 0, 16'h0, 1, 0, 16'h23, 16'h23, 0, 1, 0, "dn_wrap23");
        step(0, 0, 0, 0, 16'h0, 1, 0, 16'h23, 16'h22, 0, 0, 0, "dn22");
        step(0, 0, 0, 0, 16'h0, 1, 0, 16'h23, 16'h21, 0, 0, 0, "dn21");
        step(0, 0, 0, 0, 16'h0, 1, 0, 16'h23, 16'h20, 0, 0, 0, "dn20");
        step(0, 0, 0, 0, 16'h0, 1, 0, 16'h23, 16'h19, 0, 0, 0, "dn19_borrow_digit");

        // Loads
        step(0, 0, 0, 1, 16'h45, 0, 1, 16'h59, 16'h45, 0, 0, 0, "load45");
        step(0, 0, 0, 1, 16'h4A, 0, 1, 16'h59, 16'h00, 0, 0, 1, "load4A_err");
        step(0, 0, 0, 1, 16'h45, 0, 1, 16'h59, 16'h45, 0, 0, 0, "reload45");
        step(0, 0, 0, 1, 16'h60, 0, 1, 16'h59, 16'h00, 0, 0, 1, "load60_err");

        // Priority
        step(0, 0, 0, 1, 16'h33, 0, 1, 16'h59, 16'h33, 0, 0, 0, "load33");
        step(0, 0, 1, 1, 16'h45, 1, 1, 16'h59, 16'h00, 0, 0, 0, "clr_load_en");
        step(0, 0, 0, 1, 16'h12, 1, 1, 16'h59, 16'h12, 0, 0, 0, "load_en12");
        step(0, 0, 0, 0, 16'h0, 0, 1, 16'h59, 16'h12, 0, 0, 0, "hold12");

        // Lowered limit
        step(0, 0, 0, 1, 16'h50, 0, 1, 16'h59, 16'h50, 0, 0, 0, "load50");
        step(0, 0, 0, 0, 16'h0, 1, 1, 16'h30, 16'h00, 1, 0, 0, "up_stranded");
        step(0, 0, 0, 1, 16'h50, 0, 1, 16'h59, 16'h50, 0, 0, 0, "load50b");
        step(0, 0, 0, 0, 16'h0, 1, 0, 16'h30, 16'h30, 0, 0, 0, "dn_clamp30");

        // Decrement across a digit boundary: 10 -> 09
        step(0, 0, 0, 1, 16'h10, 0, 1, 16'h59, 16'h10, 0, 0, 0, "load10");
        step(0, 0, 0, 0, 16'h0, 1, 0, 16'h59, 16'h09, 0, 0, 0, "dn09");

        // Limit 0: back-to-back carries
        step(0, 0, 1, 0, 16'h0, 0, 1, 16'h00, 16'h00, 0, 0, 0, "clr0");
        step(0, 0, 0, 0, 16'h0, 1, 1, 16'h00, 16'h00, 1, 0, 0, "lim0_a");
        step(0, 0, 0, 0, 16'h0, 1, 1, 16'h00, 16'h00, 1, 0, 0, "lim0_b");

        // Reset mid-count overrides, then first step on next enabled edge
        step(0, 0, 0, 1, 16'h37, 0, 1, 16'h59, 16'h37, 0, 0, 0, "load37");
        step(0, 1, 0, 0, 16'h0, 1, 1, 16'h59, 16'h00, 0, 0, 0, "rst_mid");
        step(0, 0, 0, 0, 16'h0, 1, 1, 16'h59, 16'h01, 0, 0, 0, "after_rst");

        // 4-digit instance
        step(1, 0, 0, 1, 16'h0999, 0, 1, 16'h9999, 16'h0999, 0, 0, 0, "d4_load0999");
        step(1, 0, 0, 0, 16'h0, 1, 1, 16'h9999, 16'h1000, 0, 0, 0, "d4_up1000");
        step(1, 0, 0, 1, 16'h9999, 0, 1, 16'h9F99, 16'h9999, 0, 0, 0, "d4_load9999_badlim");
        step(1, 0, 0, 0, 16'h0, 1, 1, 16'h9F99, 16'h0000, 1, 0, 0, "d4_wrap_badlim");
        step(1, 0, 0, 0, 16'h0, 1, 0, 16'h9F99, 16'h9999, 0, 1, 0, "d4_dnwrap_badlim");
        step(1, 0, 0, 1, 16'h9A00, 0, 1, 16'h9999, 16'h0000, 0, 0, 1, "d4_load_err");

        // Idle both and let the monitor drain
        a_en = 1'b0; a_load = 1'b0; b_en = 1'b0; b_load = 1'b0;
        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #3;
        if (q.size() > 0) begin
            fails++;
            tests++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multi_digit_bcd_counter.md
# multi_digit_bcd_counter

Parametrised N-digit packed-BCD counter with a runtime wrap limit, up/down direction, synchronous clear, parallel load and registered wrap pulses. It is the general counting element for the timer/clock datapath. Typical uses are a 00–59 seconds/minutes stage with Limit = 8'h59, 00–23 hours, or wider event counters. Stages cascade by feeding one stage's Carry/Borrow into the next stage's En.

## Interface
- DIGITS, default 2: number of BCD digits; legal range 1–8; data width W = 4*DIGITS.
- Clk  in  1  rising-edge clock; the only clock.
- Rst  in  1  synchronous, active-high reset.
- Clr  in  1  synchronous clear of count to 0.
- Load  in  1  synchronous parallel load.
- LoadValue  in  W  packed BCD value to load.
- En  in  1  count enable; one step per cycle while high.
- Dir  in  1  1 = count up, 0 = count down.
- Limit  in  W  packed BCD terminal value; count range is 0..Limit inclusive.
- CountOut  out  W  registered packed BCD count; digit 0 in [3:0].
- Carry  out  1  registered one-cycle pulse on up-wrap Limit→0.
- Borrow  out  1  registered one-cycle pulse on down-wrap 0→Limit.
- LoadErr  out  1  registered one-cycle pulse on a rejected load.

## Operation
- Effective limit L:
  - L = Limit if every digit of Limit is ≤ 9.
  - Otherwise L = all-nines (for example 8'h99 for DIGITS = 2).
  - Packed-BCD values compare as unsigned binary.
- Per-edge priority, highest first: Rst > Clr > Load > En.
- Rst: CountOut = 0, Carry = 0, Borrow = 0, LoadErr = 0.
- Clr: CountOut = 0. Carry, Borrow and LoadErr are 0 that cycle.
- Load:
  - If every LoadValue digit is ≤ 9 and LoadValue ≤ L: CountOut = LoadValue.
  - Otherwise: CountOut = 0 and LoadErr = 1.
  - Carry and Borrow are 0 on a load cycle.
- En = 1, Dir = 1 (up):
  - If CountOut ≥ L: CountOut = 0, Carry = 1. This includes a count stranded above a lowered Limit.
  - Otherwise: BCD increment. Digit k rolls 9→0 and increments digit k+1.
- En = 1, Dir = 0 (down):
  - If CountOut = 0: CountOut = L, Borrow = 1.
  - If CountOut > L: CountOut = L, no Borrow.
  - Otherwise: BCD decrement. Digit k rolls 0→9 and borrows from digit k+1.
- En = 0: CountOut holds its value. Carry, Borrow and LoadErr are 0.
- CountOut never holds a digit > 9 and never exceeds L after any counting step.
- Limit may change on any cycle and takes effect on the next edge. Existing count is not modified until the next step.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Latency: an input sampled at edge n is reflected in CountOut after edge n.
- Carry/Borrow rise on the same edge at which CountOut takes the wrapped value, and clear on the next edge unless another wrap occurs.
- Back-to-back wraps are possible, for example Limit = 0 with En held high:
  - Carry stays high every cycle.
  - CountOut stays 0.
- Cascading: stage k+1 En = stage k Carry. This gives exactly one increment of stage k+1 per wrap of stage k, one cycle after the wrap.
- Rst mid-count overrides all other inputs on that edge. The first count step after Rst deasserts happens on the following enabled edge.

## Test plan
- Rst, then En = 1, Dir = 1, Limit = 8'h59 for 61 cycles.
  - CountOut steps 00…59, then 00, 01.
  - Carry high exactly on the cycle CountOut = 00 after 59.
- Dir = 0, Limit = 8'h23, starting from 00.
  - CountOut → 23 with Borrow = 1, then 22, 21.
  - Check 20 → 19 digit borrow.
- Load with LoadValue = 8'h45 (Limit 8'h59): CountOut = 45.
  - LoadValue = 8'h4A → CountOut = 00, LoadErr pulse.
  - LoadValue = 8'h60 → CountOut = 00, LoadErr pulse.
- Simultaneous Clr + Load + En: CountOut = 00.
  - Load + En with LoadValue = 8'h12: CountOut = 12, not 13.
- Count at 8'h50, then Limit lowered to 8'h30.
  - Up step → 00 with Carry.
  - Repeat from 50, down step → 30 with no Borrow.
- DIGITS = 4, Limit = 16'h9999, start at 16'h0999, up step: CountOut = 16'h1000.
  - Invalid Limit 16'h9F99 behaves as 16'h9999.
